// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit
// ----------------------------------------------------------------------------
// Multi-cycle multiply/divide unit for the EX stage of the 5-stage MIPS
// pipeline. It executes the MD op codes produced by the ID-stage decoder and
// owns the architectural HI/LO registers read by mfhi/mflo.
//
// A long operation (mult, multu, div, divu and optionally madd) latches its
// operands on the accepting edge and then counts down a fixed latency. HI/LO
// are written on the edge where the counter reaches zero, so the new values
// are visible in the first cycle Busy reads low. mthi/mtlo write immediately
// and never raise Busy.
//
// Parameters
//   MULT_CYCLES  Busy duration for mult/multu/madd (>= 1)
//   DIV_CYCLES   Busy duration for div/divu (>= 1)
//
// Ports
//   clk     in   1   clock, rising edge
//   reset   in   1   asynchronous active-high reset
//   Start   in   1   one-cycle strobe: EX-stage instruction is an MD op
//   MDOp    in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                    6 mtlo, 7 madd (optional)
//   RsData  in   32  operand A (dividend / multiplicand / mthi-mtlo source)
//   RtData  in   32  operand B (divisor / multiplier)
//   Busy    out  1   operation in progress
//   HI      out  32  HI register
//   LO      out  32  LO register
//
// Build option
//   MD_MADD_EN  when defined, MDOp 7 is madd: {HI,LO} += signed(Rs*Rt),
//               latency MULT_CYCLES. When undefined MDOp 7 is a no-op and
//               no accumulate datapath exists.
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MADD  = 3'd7
    } mdOp_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    mdOp_t       r_op;
    logic [CW-1:0] r_count;

    mdOp_t       w_newOp;
    logic        w_accept;
    logic        w_isMult;
    logic        w_isDiv;
    logic        w_done;

    logic [63:0] w_prodS;
    logic [63:0] w_prodU;

    logic        w_divSigned;
    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_safeB;
    logic [31:0] w_uQuot;
    logic [31:0] w_uRem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    logic        w_resWrite;
    logic [31:0] w_resHi;
    logic [31:0] w_resLo;

    assign Busy = (r_count != '0);
    assign HI   = r_hi;
    assign LO   = r_lo;

    // A new instruction is only looked at when nothing is in flight; a
    // Start that arrives while Busy is dropped without touching any state.
    assign w_newOp  = mdOp_t'(MDOp);
    assign w_accept = Start & ~Busy;
    assign w_done   = (r_count == CW'(1));

    // Classify the incoming op as a multiply-latency or divide-latency job.
    always_comb begin
        w_isMult = 1'b0;
        w_isDiv  = 1'b0;
        case (w_newOp)
            OP_MULT, OP_MULTU: w_isMult = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:           w_isMult = 1'b1;
`endif
            OP_DIV, OP_DIVU:   w_isDiv  = 1'b1;
            default: begin
                w_isMult = 1'b0;
                w_isDiv  = 1'b0;
            end
        endcase
    end

    // A 64-bit product of sign-extended operands, truncated to 64 bits, is
    // exactly the two's-complement signed product.
    assign w_prodS = {{32{r_rs[31]}}, r_rs} * {{32{r_rt[31]}}, r_rt};
    assign w_prodU = {32'd0, r_rs} * {32'd0, r_rt};

    // Signed division is done on magnitudes and the signs are restored
    // afterwards. This gives truncation toward zero, a remainder carrying the
    // dividend's sign, and makes 0x80000000 / -1 fall out as 0x80000000
    // remainder 0 without any special case.
    assign w_divSigned = (r_op == OP_DIV);
    assign w_negA      = w_divSigned & r_rs[31];
    assign w_negB      = w_divSigned & r_rt[31];
    assign w_absA      = w_negA ? (32'd0 - r_rs) : r_rs;
    assign w_absB      = w_negB ? (32'd0 - r_rt) : r_rt;
    assign w_safeB     = (w_absB == 32'd0) ? 32'd1 : w_absB;
    assign w_uQuot     = w_absA / w_safeB;
    assign w_uRem      = w_absA % w_safeB;
    assign w_quot      = (w_negA ^ w_negB) ? (32'd0 - w_uQuot) : w_uQuot;
    assign w_rem       = w_negA ? (32'd0 - w_uRem) : w_uRem;

    // Result selection for the completing operation. A zero divisor still
    // burns the full latency but leaves HI/LO untouched.
    always_comb begin
        w_resWrite = 1'b0;
        w_resHi    = r_hi;
        w_resLo    = r_lo;
        case (r_op)
            OP_MULT: begin
                w_resWrite         = 1'b1;
                {w_resHi, w_resLo} = w_prodS;
            end
            OP_MULTU: begin
                w_resWrite         = 1'b1;
                {w_resHi, w_resLo} = w_prodU;
            end
            OP_DIV, OP_DIVU: begin
                w_resWrite = (r_rt != 32'd0);
                w_resHi    = w_rem;
                w_resLo    = w_quot;
            end
`ifdef MD_MADD_EN
            OP_MADD: begin
                w_resWrite         = 1'b1;
                {w_resHi, w_resLo} = {r_hi, r_lo} + w_prodS;
            end
`endif
            default: begin
                w_resWrite = 1'b0;
                w_resHi    = r_hi;
                w_resLo    = r_lo;
            end
        endcase
    end

    // Architectural and in-flight state. Reset aborts any operation by
    // clearing the counter, so nothing can be written once it is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_rs    <= 32'd0;
            r_rt    <= 32'd0;
            r_op    <= OP_NONE;
            r_count <= '0;
        end else if (w_accept) begin
            if (w_newOp == OP_MTHI) begin
                r_hi <= RsData;
            end else if (w_newOp == OP_MTLO) begin
                r_lo <= RsData;
            end else if (w_isMult || w_isDiv) begin
                r_rs    <= RsData;
                r_rt    <= RtData;
                r_op    <= w_newOp;
                r_count <= w_isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
        end else if (Busy) begin
            r_count <= r_count - CW'(1);
            if (w_done && w_resWrite) begin
                r_hi <= w_resHi;
                r_lo <= w_resLo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit
// ----------------------------------------------------------------------------
// Scoreboard bench for mult_div_unit. The stimulus side computes the expected
// HI/LO and Busy length of every accepted operation from plain 64-bit
// arithmetic and queues it; a separate monitor pops an entry when Busy falls
// (long ops) or when a zero-latency op is due, and compares.
// ============================================================================
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        string       name;
        int          n;
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } expect_t;

    expect_t     scoreQ[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] mHi   = 32'd0;
    logic [31:0] mLo   = 32'd0;

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .RsData(RsData),
        .RtData(RtData),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to time zero-latency checks.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        total = total + 1;
        if (actual !== required) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Reference model: expected effect of an op on HI/LO and its Busy length.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string name);
        expect_t     e;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        e.name = name;
        e.n    = 0;
        e.hi   = mHi;
        e.lo   = mLo;
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        case (op)
            3'd1: begin
                e.n = MC;
                p = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            3'd2: begin
                e.n = MC;
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            3'd3: begin
                e.n = DC;
                if (b != 32'd0) begin
                    q = 64'(sa / sb);
                    r = 64'(sa % sb);
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            3'd4: begin
                e.n = DC;
                if (b != 32'd0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            3'd5: e.hi = a;
            3'd6: e.lo = a;
`ifdef MD_MADD_EN
            3'd7: begin
                e.n = MC;
                p = {mHi, mLo} + 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
`endif
            default: e.n = 0;
        endcase
        e.due = cyc + 1 + e.n;
        scoreQ.push_back(e);
        mHi    = e.hi;
        mLo    = e.lo;
        Start  = 1'b1;
        MDOp   = op;
        RsData = a;
        RtData = b;
        @(posedge clk);
        #1;
        Start  = 1'b0;
    endtask

    // Wait for Busy to drop, scrambling the operand buses meanwhile.
    task automatic waitIdle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!Busy) return;
            @(posedge clk);
            #1;
            RsData = $urandom;
            RtData = $urandom;
            MDOp   = 3'($urandom_range(0, 7));
        end
        total = total + 1;
        bad   = bad + 1;
        $display("[TB] FAIL %s busy_timeout actual=busy required=idle", name);
    endtask

    // Monitor: pops and compares whenever the DUT presents a result.
    initial begin
        int   runLen;
        logic prevBusy;
        expect_t e;
        runLen   = 0;
        prevBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                runLen   = 0;
                prevBusy = 1'b0;
            end else begin
                if (Busy) runLen = runLen + 1;
                if (prevBusy && !Busy) begin
                    if (scoreQ.size() == 0) begin
                        total = total + 1;
                        bad   = bad + 1;
                        $display("[TB] FAIL unexpected_busy actual=%0d required=0", runLen);
                    end else begin
                        e = scoreQ.pop_front();
                        checkOutput({e.name, "_busylen"}, 64'(runLen), 64'(e.n));
                        checkOutput({e.name, "_hi"}, 64'(HI), 64'(e.hi));
                        checkOutput({e.name, "_lo"}, 64'(LO), 64'(e.lo));
                    end
                    runLen = 0;
                end else if (!Busy && scoreQ.size() > 0) begin
                    if (scoreQ[0].n == 0 && cyc >= scoreQ[0].due) begin
                        e = scoreQ.pop_front();
                        checkOutput({e.name, "_busy"}, 64'(Busy), 64'd0);
                        checkOutput({e.name, "_hi"}, 64'(HI), 64'(e.hi));
                        checkOutput({e.name, "_lo"}, 64'(LO), 64'(e.lo));
                    end else if (scoreQ[0].n > 0 && cyc > scoreQ[0].due + 3) begin
                        e = scoreQ.pop_front();
                        total = total + 1;
                        bad   = bad + 1;
                        $display("[TB] FAIL %s no_completion actual=idle required=busy_%0d", e.name, e.n);
                    end
                end
                prevBusy = Busy;
            end
        end
    end

    // Hard stop in case something wedges the stimulus process.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        reset  = 1'b1;
        Start  = 1'b0;
        MDOp   = 3'd0;
        RsData = 32'd0;
        RtData = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_hi", 64'(HI), 64'd0);
        checkOutput("reset_lo", 64'(LO), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(3'd1, 32'hFFFFFFFE, 32'd3, "mult_neg");
        waitIdle("mult_neg");
        applyStimulus(3'd2, 32'hFFFFFFFE, 32'd3, "multu");
        waitIdle("multu");
        applyStimulus(3'd3, 32'hFFFFFFF9, 32'd2, "div_neg");
        waitIdle("div_neg");
        applyStimulus(3'd4, 32'd7, 32'd0, "divu_zero");
        waitIdle("divu_zero");
        applyStimulus(3'd5, 32'h12345678, 32'd0, "mthi");
        applyStimulus(3'd6, 32'h00000009, 32'd0, "mtlo");
        applyStimulus(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        waitIdle("div_ovf");
        applyStimulus(3'd0, 32'hDEADBEEF, 32'd1, "nop");

        // Second Start during a mult must be ignored; operands scrambled.
        applyStimulus(3'd1, 32'd1234, 32'hFFFFFF00, "mult_ign");
        Start  = 1'b1;
        MDOp   = 3'd3;
        RsData = $urandom;
        RtData = $urandom;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        waitIdle("mult_ign");

        // madd (or no-op when the option is absent).
        applyStimulus(3'd6, 32'hFFFFFFFF, 32'd0, "madd_setlo");
        applyStimulus(3'd5, 32'h00000000, 32'd0, "madd_sethi");
        applyStimulus(3'd7, 32'd1, 32'd1, "madd");
        waitIdle("madd");

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end else if (sel == 2) b = 32'($urandom_range(1, 15));
            applyStimulus(op, a, b, $sformatf("rand%0d_op%0d", i, op));
            waitIdle("rand");
        end

        // Reset two cycles into a mult: abort, clear, and no late write.
        @(negedge clk);
        @(posedge clk);
        #1;
        Start  = 1'b1;
        MDOp   = 3'd1;
        RsData = 32'h00001234;
        RtData = 32'h00005678;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 64'(Busy), 64'd0);
        checkOutput("abort_hi", 64'(HI), 64'd0);
        checkOutput("abort_lo", 64'(LO), 64'd0);
        mHi = 32'd0;
        mLo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("post_abort_busy", 64'(Busy), 64'd0);
        checkOutput("post_abort_hi", 64'(HI), 64'd0);
        checkOutput("post_abort_lo", 64'(LO), 64'd0);

        repeat (5) @(posedge clk);
        while (scoreQ.size() > 0) begin
            expect_t e;
            e = scoreQ.pop_front();
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL %s pending actual=unchecked required=checked", e.name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
